// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the serial subtractor reuses it as its per-bit arithmetic.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b mod 2^N, LSB first, one bit per clock,
// computed as a + ~b + 1 through a single full adder with a carry flop preset to 1.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int            CW       = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  diff_q, diff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          borrow_q, borrow_d;

    logic          b_bit_n;
    logic          fa_sum;
    logic          fa_carry;

    assign b_bit_n = ~b_q[0];

    full_adder u_full_adder (
        .a     (a_q[0]),
        .b     (b_bit_n),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    cnt_d    = '0;
                    carry_d  = 1'b1;
                    diff_d   = '0;
                    borrow_d = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                diff_d  = {fa_sum, diff_q[N-1:1]};
                carry_d = fa_carry;
                cnt_d   = cnt_q + CW'(1);
                // The final carry out of a + ~b + 1 is clear exactly when a < b.
                if (cnt_q == LAST_BIT) begin
                    borrow_d = ~fa_carry;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios, randomized operations
// and an exhaustive sweep of all operand pairs spread over parallel lanes.
module tb_serial_subtractor;

    localparam int N     = 8;
    localparam int LANES = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a, b;
    logic         busy, done, borrow;
    logic [N-1:0] diff;

    logic                      ex_start;
    logic [LANES-1:0][N-1:0]   ex_a, ex_b, ex_diff;
    logic [LANES-1:0]          ex_busy, ex_done, ex_borrow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    // Sweep lanes share clock, reset and start; lane k owns minuends with high nibble k.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        serial_subtractor #(.N(N)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .start  (ex_start),
            .a      (ex_a[g]),
            .b      (ex_b[g]),
            .busy   (ex_busy[g]),
            .done   (ex_done[g]),
            .diff   (ex_diff[g]),
            .borrow (ex_borrow[g])
        );
    end

    function automatic logic [N-1:0] ref_diff(input int x, input int y);
        int d;
        d = (x - y + (1 << N)) % (1 << N);
        return d[N-1:0];
    endfunction

    function automatic logic ref_borrow(input int x, input int y);
        return x < y;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // One operation from a start pulse; optionally scrambles inputs while it runs.
    task automatic run_op(input int x, input int y, input bit scramble);
        int cyc;
        int busy_n;
        int overlap;
        logic [N-1:0] held;
        a = N'(x); b = N'(y); start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1; busy_n = 0; overlap = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_n++;
            if (scramble) begin
                a = N'($urandom); b = N'($urandom); start = 1'($urandom_range(0, 1));
            end
            step();
            cyc++;
        end
        if (busy && done) overlap = 1;
        start = 1'b0;
        total_cnt++; if (cyc !== N + 1) $display("FAIL latency %0d-%0d: got %0d expected %0d", x, y, cyc, N + 1); else pass_cnt++;
        total_cnt++; if (busy_n !== N || overlap !== 0) $display("FAIL busy %0d-%0d: got %0d cycles overlap %0d expected %0d cycles overlap 0", x, y, busy_n, overlap, N); else pass_cnt++;
        total_cnt++; if (diff !== ref_diff(x, y)) $display("FAIL diff %0d-%0d: got %0d expected %0d", x, y, diff, ref_diff(x, y)); else pass_cnt++;
        total_cnt++; if (borrow !== ref_borrow(x, y)) $display("FAIL borrow %0d-%0d: got %0b expected %0b", x, y, borrow, ref_borrow(x, y)); else pass_cnt++;
        held = diff;
        step();
        total_cnt++; if ({done, busy, diff} !== {2'b00, held}) $display("FAIL after_done %0d-%0d: got done=%0b busy=%0b diff=%0d expected done=0 busy=0 diff=%0d", x, y, done, busy, diff, held); else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; ex_start = 1'b0; ex_a = '0; ex_b = '0;
        step(); step();
        total_cnt++; if ({busy, done, borrow, diff} !== '0) $display("FAIL reset_state: got busy=%0b done=%0b borrow=%0b diff=%0d expected all 0", busy, done, borrow, diff); else pass_cnt++;
        start = 1'b1; a = 8'd7; b = 8'd1;
        step(); step();
        total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL reset_priority: got busy=%0b done=%0b expected 0 0", busy, done); else pass_cnt++;
        rst = 1'b0; start = 1'b0;
        step();
    endtask

    task automatic test_basic();
        run_op(5, 3, 1'b0);
    endtask

    task automatic test_boundaries();
        run_op(3, 5, 1'b0);
        run_op(0, 1, 1'b0);
        run_op(255, 255, 1'b0);
        run_op(0, 0, 1'b0);
        run_op(255, 0, 1'b0);
        run_op(0, 255, 1'b0);
    endtask

    task automatic test_ignore_start();
        int n_done;
        int done_cyc;
        logic [N-1:0] d;
        logic br;
        a = 8'd10; b = 8'd4; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        start = 1'b1; a = 8'd1; b = 8'd2;
        step();
        start = 1'b0;
        n_done = 0; done_cyc = 0; d = '0; br = 1'b1;
        for (int c = 5; c < 22; c++) begin
            if (done) begin
                n_done++; done_cyc = c; d = diff; br = borrow;
            end
            step();
        end
        total_cnt++; if (n_done !== 1 || done_cyc !== N + 1) $display("FAIL ignore_start_pulses: got %0d pulses at cycle %0d expected 1 at cycle %0d", n_done, done_cyc, N + 1); else pass_cnt++;
        total_cnt++; if ({br, d} !== {1'b0, 8'd6}) $display("FAIL ignore_start_result: got diff=%0d borrow=%0b expected diff=6 borrow=0", d, br); else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int n_done;
        a = 8'd200; b = 8'd100; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        total_cnt++; if ({busy, done, borrow, diff} !== '0) $display("FAIL abort_state: got busy=%0b done=%0b borrow=%0b diff=%0d expected all 0", busy, done, borrow, diff); else pass_cnt++;
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) n_done++;
            step();
        end
        total_cnt++; if (n_done !== 0) $display("FAIL abort_no_done: got %0d pulses expected 0", n_done); else pass_cnt++;
        run_op(9, 9, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);
        end
    endtask

    // Start held high: lanes run back to back; operands change during each DONE cycle.
    task automatic test_back_to_back_exhaustive();
        int cyc;
        int exp_cyc;
        int x, y;
        for (int i = 0; i < 4096; i++) begin
            for (int k = 0; k < LANES; k++) begin
                ex_a[k] = {k[3:0], i[11:8]};
                ex_b[k] = i[7:0];
            end
            ex_start = 1'b1;
            cyc = 0;
            do begin
                step();
                cyc++;
            end while (!ex_done[0] && cyc < 30);
            exp_cyc = (i == 0) ? N + 1 : N + 2;
            total_cnt++;
            if (cyc !== exp_cyc) begin
                $display("FAIL b2b_period op %0d: got %0d cycles expected %0d", i, cyc, exp_cyc);
                break;
            end else pass_cnt++;
            for (int k = 0; k < LANES; k++) begin
                x = int'(ex_a[k]);
                y = int'(ex_b[k]);
                total_cnt++;
                if ({ex_done[k], ex_busy[k], ex_borrow[k], ex_diff[k]} !== {1'b1, 1'b0, ref_borrow(x, y), ref_diff(x, y)})
                    $display("FAIL sweep %0d-%0d: got done=%0b busy=%0b borrow=%0b diff=%0d expected done=1 busy=0 borrow=%0b diff=%0d",
                             x, y, ex_done[k], ex_busy[k], ex_borrow[k], ex_diff[k], ref_borrow(x, y), ref_diff(x, y));
                else pass_cnt++;
            end
        end
        ex_start = 1'b0;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_ignore_start();
        test_reset_abort();
        test_random();
        test_back_to_back_exhaustive();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
